// File: rtl/axis_uart_pkg.sv
// Shared arbiter definitions: FSM state encoding and requester count.
package axis_uart_pkg;

  localparam int unsigned NumPorts = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axis_fifo_arbiter.sv
// Two-port AXI-Stream to FIFO write-port arbiter with packet-atomic round-robin
// grants and a sticky mid-packet idle timeout.
module axis_fifo_arbiter
  import axis_uart_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_din_last,
  input  logic             fifo_full,
  output logic [NumPorts-1:0] grant,
  output logic             err_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  arb_state_e      state_q;
  logic            last_served_q;
  logic [CntW-1:0] idle_cnt_q;
  logic            err_timeout_q;

  logic             active;
  logic             sel1;
  logic             cur_valid;
  logic             cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             idle_tick;
  logic             timeout_hit;

  always_comb begin
    active    = (state_q == StGrant0) || (state_q == StGrant1);
    sel1      = (state_q == StGrant1);
    cur_valid = sel1 ? s1_tvalid : s0_tvalid;
    cur_last  = sel1 ? s1_tlast  : s0_tlast;
    cur_data  = sel1 ? s1_tdata  : s0_tdata;

    s0_tready     = (state_q == StGrant0) && !fifo_full;
    s1_tready     = (state_q == StGrant1) && !fifo_full;
    fifo_wr_en    = active && cur_valid && !fifo_full;
    fifo_din      = active ? cur_data : '0;
    fifo_din_last = active && cur_last;
    grant         = {state_q == StGrant1, state_q == StGrant0};
    err_timeout   = err_timeout_q;

    // A full FIFO is a stall, not requester idleness.
    idle_tick   = active && !cur_valid && !fifo_full;
    timeout_hit = idle_tick && (idle_cnt_q == CntW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      idle_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idle_cnt_q <= '0;
          if (s0_tvalid && s1_tvalid) begin
            state_q <= last_served_q ? StGrant0 : StGrant1;
          end else if (s0_tvalid) begin
            state_q <= StGrant0;
          end else if (s1_tvalid) begin
            state_q <= StGrant1;
          end
        end
        StGrant0, StGrant1: begin
          if (fifo_wr_en) begin
            idle_cnt_q <= '0;
            if (cur_last) begin
              state_q       <= StIdle;
              last_served_q <= sel1;
            end
          end else if (timeout_hit) begin
            state_q       <= StIdle;
            last_served_q <= sel1;
            err_timeout_q <= 1'b1;
            idle_cnt_q    <= '0;
          end else if (idle_tick) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          idle_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Scoreboard bench for axis_fifo_arbiter: queued requester beats, expected FIFO
// writes checked by an independent monitor, plus directed stall/timeout/reset checks.
module tb_axis_fifo_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] grant;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] s0_tdata, s1_tdata;
  logic       s0_tvalid, s0_tlast, s0_tready;
  logic       s1_tvalid, s1_tlast, s1_tready;
  logic       fifo_wr_en, fifo_din_last, fifo_full;
  logic [7:0] fifo_din;
  logic [1:0] grant;
  logic       err_timeout;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];
  int    wr_cyc[$];
  int    nvec = 0;
  int    nerr = 0;
  int    wr_cnt = 0;
  int    cyc = 0;
  logic  prev_last = 1'b0;

  axis_fifo_arbiter #(
    .WIDTH  (8),
    .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s0_tdata     (s0_tdata),
    .s0_tvalid    (s0_tvalid),
    .s0_tlast     (s0_tlast),
    .s0_tready    (s0_tready),
    .s1_tdata     (s1_tdata),
    .s1_tvalid    (s1_tvalid),
    .s1_tlast     (s1_tlast),
    .s1_tready    (s1_tready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .fifo_din_last(fifo_din_last),
    .fifo_full    (fifo_full),
    .grant        (grant),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push0(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    q0.push_back(b);
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    q1.push_back(b);
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic l, input logic [1:0] g);
    exp_t e;
    e.data = d; e.last = l; e.grant = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (wr_cnt < target) chk("write_count_bound", wr_cnt, target);
  endtask

  // Requester drivers: present the head beat, pop it after a sampled handshake.
  initial begin : drv0
    logic hs;
    forever begin
      @(negedge clk);
      hs = s0_tvalid && s0_tready && rst_n;
      @(posedge clk);
      #1;
      if (hs && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        s0_tvalid = 1'b1; s0_tdata = q0[0].data; s0_tlast = q0[0].last;
      end else begin
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
      end
    end
  end

  initial begin : drv1
    logic hs;
    forever begin
      @(negedge clk);
      hs = s1_tvalid && s1_tready && rst_n;
      @(posedge clk);
      #1;
      if (hs && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        s1_tvalid = 1'b1; s1_tdata = q1[0].data; s1_tlast = q1[0].last;
      end else begin
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        if (fifo_wr_en) chk("write_in_reset", {31'd0, fifo_wr_en}, 32'd0);
        prev_last = 1'b0;
      end else begin
        if (fifo_wr_en) begin
          chk("bubble_after_last", {31'd0, prev_last}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {24'd0, fifo_din}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("fifo_din", {24'd0, fifo_din}, {24'd0, e.data});
            chk("fifo_din_last", {31'd0, fifo_din_last}, {31'd0, e.last});
            chk("grant_on_write", {30'd0, grant}, {30'd0, e.grant});
          end
          wr_cnt++;
          wr_cyc.push_back(cyc);
        end
        prev_last = fifo_wr_en && fifo_din_last;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; fifo_full = 1'b0;
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    #23 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_s0_tready", {31'd0, s0_tready}, 32'd0);
    chk("rst_s1_tready", {31'd0, s1_tready}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_din", {24'd0, fifo_din}, 32'd0);
    chk("rst_din_last", {31'd0, fifo_din_last}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);

    // Contention after reset: s0 wins, whole packet, then s1
    #1;
    push0(8'h11, 0); push0(8'h12, 0); push0(8'h13, 0); push0(8'h14, 1);
    push1(8'hA1, 0); push1(8'hA2, 1);
    expect_wr(8'h11, 0, 2'b01); expect_wr(8'h12, 0, 2'b01);
    expect_wr(8'h13, 0, 2'b01); expect_wr(8'h14, 1, 2'b01);
    expect_wr(8'hA1, 0, 2'b10); expect_wr(8'hA2, 1, 2'b10);
    wait_writes(6, 100);

    // Back-to-back single-beat packets alternate with exactly one idle cycle
    @(negedge clk); #1;
    push0(8'h21, 1); push0(8'h22, 1);
    push1(8'h31, 1); push1(8'h32, 1);
    expect_wr(8'h21, 1, 2'b01); expect_wr(8'h31, 1, 2'b10);
    expect_wr(8'h22, 1, 2'b01); expect_wr(8'h32, 1, 2'b10);
    wait_writes(10, 100);
    if (wr_cyc.size() >= 10) begin
      for (int i = 6; i < 9; i++) chk("single_beat_gap", wr_cyc[i+1] - wr_cyc[i], 32'd2);
    end

    // FIFO full for 3 cycles mid-packet on s1
    @(negedge clk); #1;
    push1(8'hB1, 0); push1(8'hB2, 0); push1(8'hB3, 0); push1(8'hB4, 1);
    expect_wr(8'hB1, 0, 2'b10); expect_wr(8'hB2, 0, 2'b10);
    expect_wr(8'hB3, 0, 2'b10); expect_wr(8'hB4, 1, 2'b10);
    wait_writes(11, 100);
    #1 fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_s1_tready", {31'd0, s1_tready}, 32'd0);
      chk("full_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      chk("full_grant", {30'd0, grant}, 32'd2);
    end
    @(posedge clk); #1 fifo_full = 1'b0;
    wait_writes(14, 100);

    // Mid-packet timeout on s0 (TIMEOUT=4), s1 pending
    @(negedge clk); #1;
    push0(8'hC1, 0); push0(8'hC2, 0);
    push1(8'hD1, 1);
    expect_wr(8'hC1, 0, 2'b01); expect_wr(8'hC2, 0, 2'b01);
    expect_wr(8'hD1, 1, 2'b10);
    wait_writes(16, 100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_grant_held", {30'd0, grant}, 32'd1);
      chk("idle_err_low", {31'd0, err_timeout}, 32'd0);
    end
    @(negedge clk);
    chk("timeout_grant", {30'd0, grant}, 32'd0);
    chk("timeout_err", {31'd0, err_timeout}, 32'd1);
    chk("timeout_din", {24'd0, fifo_din}, 32'd0);
    wait_writes(17, 100);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);

    // s0 completes a packet (last_served=0), then reset mid-packet on s0
    #1;
    push0(8'h41, 1);
    push0(8'hF1, 0); push0(8'hF2, 0); push0(8'hF3, 0); push0(8'hF4, 1);
    expect_wr(8'h41, 1, 2'b01);
    expect_wr(8'hF1, 0, 2'b01); expect_wr(8'hF2, 0, 2'b01);
    wait_writes(20, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", {30'd0, grant}, 32'd0);
    chk("async_rst_s0_tready", {31'd0, s0_tready}, 32'd0);
    chk("async_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("async_rst_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk); #1;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    chk("held_rst_grant", {30'd0, grant}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    // First arbitration after reset goes to s0 again
    @(negedge clk); #1;
    push0(8'h51, 1);
    push1(8'h61, 1);
    expect_wr(8'h51, 1, 2'b01);
    expect_wr(8'h61, 1, 2'b10);
    wait_writes(22, 100);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axis_fifo_arbiter.md
AXIS_FIFO_ARBITER -- requirements
Module: axis_fifo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-002 SHALL have parameter TIMEOUT, default 255 (range 1..65535), mid-packet idle limit in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports s0_tdata  input  WIDTH, s0_tvalid  input  1, s0_tlast  input  1: requester 0 AXI-Stream.
REQ-006 SHALL have port s0_tready  output  1  requester 0 accept.
REQ-007 SHALL have ports s1_tdata  input  WIDTH, s1_tvalid  input  1, s1_tlast  input  1: requester 1 AXI-Stream.
REQ-008 SHALL have port s1_tready  output  1  requester 1 accept.
REQ-009 SHALL have ports fifo_wr_en  output  1, fifo_din  output  WIDTH, fifo_din_last  output  1: shared FIFO write port.
REQ-010 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-011 SHALL have port grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-012 SHALL have port err_timeout  output  1  sticky mid-packet timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-014 IDLE: no transfers; tready both 0; fifo_wr_en 0.
REQ-015 IDLE, only sN_tvalid high: next state GRANTN.
REQ-016 IDLE, both tvalid high: grant the port not in last_served (round-robin); last_served resets to 1 so port 0 wins first contention.
REQ-017 GRANTN: sN_tready = !fifo_full; other port tready = 0.
REQ-018 GRANTN: fifo_wr_en = sN_tvalid && !fifo_full; fifo_din = sN_tdata; fifo_din_last = sN_tlast; combinational, zero latency.
REQ-019 fifo_din and fifo_din_last SHALL be 0 when no port is granted.
REQ-020 A beat transfers iff tvalid && tready in GRANTN; transferring a beat with tlast=1 SHALL return FSM to IDLE next cycle and set last_served=N.
REQ-021 Grant SHALL be packet-atomic: no switch before tlast beat or timeout.
REQ-022 fifo_full high: stall, no beat, grant held, idle counter not incremented.
REQ-023 Idle counter ($clog2(TIMEOUT+1) bits) SHALL increment each GRANTN cycle with sN_tvalid=0 and fifo_full=0, clear on any transfer or in IDLE.
REQ-024 Counter reaching TIMEOUT SHALL force IDLE next cycle, set last_served=N, set err_timeout=1; no terminating beat is written.
REQ-025 err_timeout SHALL stay 1 until reset.
REQ-026 Minimum packet cadence: one IDLE bubble cycle between consecutive packets.
REQ-027 Single-beat packet (tlast on first beat) SHALL be legal: GRANTN for 1 cycle then IDLE.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, last_served=1, idle counter 0, err_timeout 0, grant 2'b00, both tready 0, fifo_wr_en 0.
REQ-029 Reset mid-packet SHALL abandon the packet; no write occurs while rst_n low; first post-reset arbitration follows REQ-016.

Structure
REQ-030 FSM state encodings and port-count constant SHALL live in the shared package axis_uart_pkg.
REQ-031 SHALL be a single module with no sub-modules; the round-robin pick is inline logic.
REQ-032 Only state, last_served, idle counter and err_timeout SHALL be registered; datapath mux is combinational.

Verification
REQ-033 Both valid after reset, s0 4-beat packet 0x11..0x14, s1 2-beat 0xA1,0xA2 -> FIFO receives 0x11..0x14 (last on 0x14), bubble, then 0xA1,0xA2 (last on 0xA2); grant 01 then 10.
REQ-034 Three back-to-back single-beat packets from both ports continuously valid -> writes alternate s0,s1,s0 with one IDLE cycle between each.
REQ-035 fifo_full held high 3 cycles mid-packet on s1 -> s1_tready 0, fifo_wr_en 0 for 3 cycles, grant stays 10, no data lost or duplicated.
REQ-036 TIMEOUT=4, s0 sends 2 beats then drops tvalid -> after 4 idle cycles grant 00, err_timeout 1 and held, pending s1 packet granted next.
REQ-037 rst_n asserted mid-packet on s0 -> grant 00, tready 0 immediately (asynchronous); after release, s0 and s1 both valid -> s0 granted first.
